// File: rtl/next_pc_gen_pkg.sv
// Shared types for next-PC generation: 2-bit branch counter encodings and BTB entry metadata.
package next_pc_gen_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RST   = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Tag and target widths depend on the WIDTH/IDX_BITS parameters, so they live
  // in parallel arrays next to this per-entry metadata.
  typedef struct packed {
    logic valid;
    ctr_t ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/next_pc_gen_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, edge-triggered update.
// Storage exists only when NEXT_PC_BPRED_EN is defined; otherwise it always predicts not-taken.
module next_pc_btb
  import next_pc_gen_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int IDX_BITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_lookup_pc,
  input  logic             i_upd_valid,
  input  logic [WIDTH-1:0] i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [WIDTH-1:0] i_upd_target,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_target
);

`ifdef NEXT_PC_BPRED_EN
  localparam int TAG_W   = WIDTH - IDX_BITS;
  localparam int ENTRIES = 1 << IDX_BITS;

  btb_entry_t       meta [ENTRIES];
  logic [TAG_W-1:0] tag  [ENTRIES];
  logic [WIDTH-1:0] tgt  [ENTRIES];

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit;

  assign l_idx = i_lookup_pc[IDX_BITS-1:0];
  assign l_tag = i_lookup_pc[WIDTH-1:IDX_BITS];
  assign u_idx = i_upd_pc[IDX_BITS-1:0];
  assign u_tag = i_upd_pc[WIDTH-1:IDX_BITS];

  assign l_hit = meta[l_idx].valid && (tag[l_idx] == l_tag);
  assign u_hit = meta[u_idx].valid && (tag[u_idx] == u_tag);

  assign o_pred_taken  = l_hit && ctr_taken(meta[l_idx].ctr);
  assign o_pred_target = l_hit ? tgt[l_idx] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        meta[i] <= '{valid: 1'b0, ctr: CTR_RST};
        tag[i]  <= '0;
        tgt[i]  <= '0;
      end
    end else if (i_upd_valid) begin
      if (i_upd_taken) begin
        tgt[u_idx] <= i_upd_target;
        if (u_hit) begin
          meta[u_idx].ctr <= ctr_inc(meta[u_idx].ctr);
        end else begin
          // Miss on a taken branch replaces whatever alias occupied the slot.
          meta[u_idx] <= '{valid: 1'b1, ctr: CTR_ALLOC};
          tag[u_idx]  <= u_tag;
        end
      end else if (u_hit) begin
        meta[u_idx].ctr <= ctr_dec(meta[u_idx].ctr);
      end
    end
  end
`else
  logic unused_btb;
  assign unused_btb = ^{i_clk, i_rst, i_lookup_pc, i_upd_valid, i_upd_pc,
                        i_upd_taken, i_upd_target};
  assign o_pred_taken  = 1'b0;
  assign o_pred_target = '0;
`endif

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC select: reset > redirect > stall > BTB prediction > PC+1 (wrapping).
// Branch prediction is present only with NEXT_PC_BPRED_EN defined (see next_pc_btb).
module next_pc_gen
  import next_pc_gen_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int IDX_BITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_resolve_valid,
  input  logic [WIDTH-1:0] i_resolve_pc,
  input  logic             i_resolve_taken,
  input  logic [WIDTH-1:0] i_resolve_target,
  output logic [WIDTH-1:0] o_pc_next,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_target
);

  logic             btb_taken;
  logic [WIDTH-1:0] btb_target;
  logic [WIDTH-1:0] pc_inc;

  next_pc_btb #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) u_btb (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_lookup_pc   (i_pc),
    .i_upd_valid   (i_resolve_valid),
    .i_upd_pc      (i_resolve_pc),
    .i_upd_taken   (i_resolve_taken),
    .i_upd_target  (i_resolve_target),
    .o_pred_taken  (btb_taken),
    .o_pred_target (btb_target)
  );

  // Carry out is dropped so the PC wraps modulo 2**WIDTH.
  assign pc_inc = i_pc + {{(WIDTH-1){1'b0}}, 1'b1};

  assign o_pred_taken  = btb_taken && !i_rst;
  assign o_pred_target = btb_target;

  always_comb begin
    o_pc_next = pc_inc;
    if (i_rst)             o_pc_next = '0;
    else if (i_redirect)   o_pc_next = i_redirect_pc;
    else if (i_stall)      o_pc_next = i_pc;
    else if (o_pred_taken) o_pc_next = btb_target;
  end

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed self-checking bench for next_pc_gen; expectations follow NEXT_PC_BPRED_EN.
module tb_next_pc_gen;
  import next_pc_gen_pkg::*;

  localparam int W = 14;
`ifdef NEXT_PC_BPRED_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [W-1:0] i_pc;
  logic         i_stall;
  logic         i_redirect;
  logic [W-1:0] i_redirect_pc;
  logic         i_resolve_valid;
  logic [W-1:0] i_resolve_pc;
  logic         i_resolve_taken;
  logic [W-1:0] i_resolve_target;
  logic [W-1:0] o_pc_next;
  logic         o_pred_taken;
  logic [W-1:0] o_pred_target;

  int n_cmp = 0;
  int n_err = 0;

  next_pc_gen #(.WIDTH(W), .IDX_BITS(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_resolve_valid(i_resolve_valid), .i_resolve_pc(i_resolve_pc),
    .i_resolve_taken(i_resolve_taken), .i_resolve_target(i_resolve_target),
    .o_pc_next(o_pc_next), .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target)
  );

  always #5 i_clk = ~i_clk;

  // One resolve pulse spanning exactly one rising edge.
  task automatic resolve(input logic [W-1:0] pc, input logic taken, input logic [W-1:0] tgt);
    @(negedge i_clk);
    i_resolve_valid = 1'b1; i_resolve_pc = pc; i_resolve_taken = taken; i_resolve_target = tgt;
    @(negedge i_clk);
    i_resolve_valid = 1'b0;
  endtask

  task automatic look(input logic [W-1:0] pc);
    i_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b1; i_redirect_pc = 14'h0200;
    i_resolve_valid = 1'b0; i_resolve_pc = '0; i_resolve_taken = 1'b0; i_resolve_target = '0;
    i_pc = 14'h0055;
    repeat (2) @(negedge i_clk);
    #1;
    n_cmp++; if (o_pc_next !== 14'h0000) begin n_err++; $display("FAIL reset_pc_next: got %h want %h", o_pc_next, 14'h0000); end
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %b want 0", o_pred_taken); end
    i_rst = 1'b0; i_redirect = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_increment;
    look(14'h0000);
    n_cmp++; if (o_pc_next !== 14'h0001) begin n_err++; $display("FAIL inc_zero: got %h want %h", o_pc_next, 14'h0001); end
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL inc_zero_pred: got %b want 0", o_pred_taken); end
    look(14'h3FFF);
    n_cmp++; if (o_pc_next !== 14'h0000) begin n_err++; $display("FAIL inc_wrap: got %h want %h", o_pc_next, 14'h0000); end
    look(14'h1234);
    n_cmp++; if (o_pc_next !== 14'h1235) begin n_err++; $display("FAIL inc_mid: got %h want %h", o_pc_next, 14'h1235); end
  endtask

  task automatic test_train;
    @(negedge i_clk);
    i_resolve_valid = 1'b1; i_resolve_pc = 14'h0012; i_resolve_taken = 1'b1; i_resolve_target = 14'h0100;
    look(14'h0012);
    n_cmp++; if (o_pc_next !== 14'h0013) begin n_err++; $display("FAIL train_same_cycle: got %h want %h", o_pc_next, 14'h0013); end
    @(negedge i_clk);
    i_resolve_valid = 1'b0;
    #1;
    n_cmp++; if (o_pred_taken !== BP) begin n_err++; $display("FAIL train_pred: got %b want %b", o_pred_taken, BP); end
    n_cmp++; if (o_pc_next !== (BP ? 14'h0100 : 14'h0013)) begin n_err++; $display("FAIL train_pc_next: got %h want %h", o_pc_next, BP ? 14'h0100 : 14'h0013); end
    n_cmp++; if (o_pred_target !== (BP ? 14'h0100 : 14'h0000)) begin n_err++; $display("FAIL train_target: got %h want %h", o_pred_target, BP ? 14'h0100 : 14'h0000); end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 3; k++) resolve(14'h0012, 1'b1, 14'h0100);
    resolve(14'h0012, 1'b0, 14'h0000);
    look(14'h0012);
    n_cmp++; if (o_pc_next !== (BP ? 14'h0100 : 14'h0013)) begin n_err++; $display("FAIL sat_one_nt: got %h want %h", o_pc_next, BP ? 14'h0100 : 14'h0013); end
    n_cmp++; if (o_pred_taken !== BP) begin n_err++; $display("FAIL sat_one_nt_pred: got %b want %b", o_pred_taken, BP); end
    resolve(14'h0012, 1'b0, 14'h0000);
    look(14'h0012);
    n_cmp++; if (o_pc_next !== 14'h0013) begin n_err++; $display("FAIL sat_two_nt: got %h want %h", o_pc_next, 14'h0013); end
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_two_nt_pred: got %b want 0", o_pred_taken); end
    // Still-valid weak-NT entry moves back to weak-T with one taken resolve.
    resolve(14'h0012, 1'b1, 14'h0140);
    look(14'h0012);
    n_cmp++; if (o_pc_next !== (BP ? 14'h0140 : 14'h0013)) begin n_err++; $display("FAIL sat_retrain: got %h want %h", o_pc_next, BP ? 14'h0140 : 14'h0013); end
  endtask

  task automatic test_alias;
    look(14'h0022);
    n_cmp++; if (o_pc_next !== 14'h0023) begin n_err++; $display("FAIL alias_miss: got %h want %h", o_pc_next, 14'h0023); end
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_miss_pred: got %b want 0", o_pred_taken); end
    resolve(14'h0022, 1'b1, 14'h0300);
    look(14'h0022);
    n_cmp++; if (o_pc_next !== (BP ? 14'h0300 : 14'h0023)) begin n_err++; $display("FAIL alias_replace: got %h want %h", o_pc_next, BP ? 14'h0300 : 14'h0023); end
    look(14'h0012);
    n_cmp++; if (o_pc_next !== 14'h0013) begin n_err++; $display("FAIL alias_evicted: got %h want %h", o_pc_next, 14'h0013); end
    resolve(14'h0045, 1'b0, 14'h0777);
    look(14'h0045);
    n_cmp++; if (o_pc_next !== 14'h0046) begin n_err++; $display("FAIL nt_miss_noalloc: got %h want %h", o_pc_next, 14'h0046); end
  endtask

  task automatic test_priority;
    i_redirect = 1'b1; i_redirect_pc = 14'h0200; i_stall = 1'b1;
    look(14'h0022);
    n_cmp++; if (o_pc_next !== 14'h0200) begin n_err++; $display("FAIL prio_redirect: got %h want %h", o_pc_next, 14'h0200); end
    i_redirect = 1'b0;
    #1;
    n_cmp++; if (o_pc_next !== 14'h0022) begin n_err++; $display("FAIL prio_stall: got %h want %h", o_pc_next, 14'h0022); end
    i_stall = 1'b0;
    #1;
    n_cmp++; if (o_pc_next !== (BP ? 14'h0300 : 14'h0023)) begin n_err++; $display("FAIL prio_pred: got %h want %h", o_pc_next, BP ? 14'h0300 : 14'h0023); end
  endtask

  task automatic test_update_during_stall;
    @(negedge i_clk);
    i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 14'h0010;
    i_resolve_valid = 1'b1; i_resolve_pc = 14'h0050; i_resolve_taken = 1'b1; i_resolve_target = 14'h0060;
    @(negedge i_clk);
    i_stall = 1'b0; i_redirect = 1'b0; i_resolve_valid = 1'b0;
    look(14'h0050);
    n_cmp++; if (o_pc_next !== (BP ? 14'h0060 : 14'h0051)) begin n_err++; $display("FAIL upd_in_stall: got %h want %h", o_pc_next, BP ? 14'h0060 : 14'h0051); end
  endtask

  task automatic test_reset_midrun;
    @(negedge i_clk);
    i_rst = 1'b1;
    i_resolve_valid = 1'b1; i_resolve_pc = 14'h0033; i_resolve_taken = 1'b1; i_resolve_target = 14'h0400;
    look(14'h0022);
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL midrst_pred_in_reset: got %b want 0", o_pred_taken); end
    @(negedge i_clk);
    i_rst = 1'b0; i_resolve_valid = 1'b0;
    look(14'h0022);
    n_cmp++; if (o_pc_next !== 14'h0023) begin n_err++; $display("FAIL midrst_cleared: got %h want %h", o_pc_next, 14'h0023); end
    n_cmp++; if (o_pred_target !== 14'h0000) begin n_err++; $display("FAIL midrst_target: got %h want %h", o_pred_target, 14'h0000); end
    look(14'h0050);
    n_cmp++; if (o_pc_next !== 14'h0051) begin n_err++; $display("FAIL midrst_cleared2: got %h want %h", o_pc_next, 14'h0051); end
    look(14'h0033);
    n_cmp++; if (o_pc_next !== 14'h0034) begin n_err++; $display("FAIL midrst_upd_ignored: got %h want %h", o_pc_next, 14'h0034); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_train();
    test_saturation();
    test_alias();
    test_priority();
    test_update_during_stall();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/next_pc_gen.md
# next_pc_gen

Next-PC generation stage sitting directly upstream of the program counter register: it computes the value loaded into the PC each cycle. It selects among sequential fetch (PC+1), a predicted branch target from a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters, a stall hold, and an execute-stage redirect on mispredict. Predictor state is updated when branches resolve.

## Interface
Parameters:
- WIDTH, 14, PC width in bits (word-addressed instruction memory)
- IDX_BITS, 4, BTB index width; 2**IDX_BITS entries

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_pc  input  WIDTH  current PC (output of the PC register)
- i_stall  input  1  hold PC (fetch/decode stall)
- i_redirect  input  1  mispredict detected in execute; overrides prediction
- i_redirect_pc  input  WIDTH  correct next PC on redirect
- i_resolve_valid  input  1  a branch/jump resolved this cycle
- i_resolve_pc  input  WIDTH  PC of the resolved branch
- i_resolve_taken  input  1  actual outcome
- i_resolve_target  input  WIDTH  actual taken target
- o_pc_next  output  WIDTH  value to load into the PC register
- o_pred_taken  output  1  prediction made for i_pc; carried down the pipeline
- o_pred_target  output  WIDTH  predicted target for i_pc (valid when o_pred_taken)

## Operation
- BTB entry: valid bit, tag = pc[WIDTH-1:IDX_BITS], target WIDTH bits, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup (combinational on i_pc): index = i_pc[IDX_BITS-1:0]; hit = valid && tag match; o_pred_taken = hit && counter[1]; o_pred_target = entry target (0 when no hit).
- o_pc_next priority: i_rst -> 0; i_redirect -> i_redirect_pc; i_stall -> i_pc; o_pred_taken -> o_pred_target; else i_pc + 1.
- PC+1 wraps modulo 2**WIDTH (0x3FFF -> 0x0000 at WIDTH=14); no carry out.
- Update on i_resolve_valid (index/tag from i_resolve_pc):
  - taken, hit: counter saturating increment, target overwritten with i_resolve_target.
  - taken, miss: allocate (replace): valid=1, tag, target written, counter=10.
  - not taken, hit: counter saturating decrement; entry stays valid.
  - not taken, miss: no change.
- Update proceeds regardless of i_stall and i_redirect.

## Timing
- o_pc_next, o_pred_taken, o_pred_target: combinational from i_pc and current table state; zero latency.
- Table writes take effect at the rising edge; a lookup of the same index in the same cycle sees the pre-update contents.
- Reset (synchronous): all valid bits cleared, counters = 01, targets = 0; while i_rst is high, o_pc_next = 0, o_pred_taken = 0, and resolve updates are ignored. Reset mid-operation discards all predictor state.
- Redirect and stall in same cycle: redirect wins.

## Configuration
- NEXT_PC_BPRED_EN defined: BTB and counters as above.
- Undefined: no table storage; o_pred_taken = 0, o_pred_target = 0, o_pc_next chooses only reset/redirect/stall/PC+1 (static predict-not-taken); resolve inputs ignored. Ports unchanged.

## Structure
- Shared package: counter encodings (SNT/WNT/WT/ST), counter reset value, BTB entry struct type.
- One sub-module: next_pc_btb (storage, lookup, update); next_pc_gen holds the select mux and wrap-around increment.

## Test plan
- Reset then free-run from i_pc=0x0000 -> o_pc_next=0x0001, o_pred_taken=0; i_pc=0x3FFF -> o_pc_next=0x0000.
- Resolve taken i_resolve_pc=0x0012, target 0x0100; next cycle i_pc=0x0012 -> o_pred_taken=1, o_pc_next=0x0100; same-cycle lookup during the write -> o_pc_next=0x0013.
- Counter saturation: three further taken resolves on 0x0012 then one not-taken -> still predicts taken (11->10); second not-taken -> predicts not-taken, o_pc_next=0x0013.
- Aliasing: entry for 0x0012, lookup i_pc=0x0022 (same index, different tag) -> miss, o_pc_next=0x0023; taken resolve at 0x0022 replaces entry, 0x0012 then misses.
- Priority: i_redirect=1 (0x0200), i_stall=1, BTB hit -> o_pc_next=0x0200; i_stall only -> o_pc_next=i_pc.
- Reset mid-run after training -> all lookups miss; with NEXT_PC_BPRED_EN undefined, trained sequence still yields PC+1 and o_pred_taken=0.
